// File: rtl/rn_release_sequencer.sv
// rtl/rn_release_sequencer.sv - staggered release generator for active-low RN domain resets
module rn_release_sequencer #(
  parameter int N_OUT       = 4,
  parameter int HOLD_CYC    = 8,
  parameter int STAGGER_CYC = 4,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sw_rst_req,
  output logic [N_OUT-1:0] o_rn,
  output logic             o_busy,
  output logic             o_done
);

  localparam int IDX_W = $clog2(N_OUT) + 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [N_OUT-1:0] r_rn;
  logic [N_OUT-1:0] w_rn_nxt;
  logic             r_busy;
  logic             r_done;

  // BUSY/DONE are decoded from the next state so they move on the same edge as it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rn    <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rn    <= w_rn_nxt;
      r_busy  <= (w_state_nxt != ST_RUN);
      r_done  <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rn_nxt    = r_rn;
    if (i_sw_rst_req) begin
      w_state_nxt = ST_ASSERT;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rn_nxt    = '0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_rn_nxt = '0;
          if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
            w_rn_nxt[0] = 1'b1;
            w_cnt_nxt   = '0;
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = (N_OUT == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt == CNT_W'(STAGGER_CYC - 1)) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + IDX_W'(1);
            for (int i = 0; i < N_OUT; i++) begin
              if (r_idx == IDX_W'(i)) begin
                w_rn_nxt[i] = 1'b1;
              end
            end
            if (r_idx == IDX_W'(N_OUT - 1)) begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          w_rn_nxt = '1;
        end
        default: begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rn_nxt    = '0;
        end
      endcase
    end
  end

  assign o_rn   = r_rn;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_rn_release_sequencer.sv
// tb/tb_rn_release_sequencer.sv - directed bench for rn_release_sequencer
module tb_rn_release_sequencer;

  localparam int HOLD = 8;
  localparam int STAG = 4;
  localparam int NO   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sw;
  logic [NO-1:0] rn;
  logic          busy;
  logic          done;
  logic          rst1;
  logic          sw1;
  logic [0:0]    rn1;
  logic          busy1;
  logic          done1;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  rn_release_sequencer #(.N_OUT(NO), .HOLD_CYC(HOLD), .STAGGER_CYC(STAG), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sw_rst_req(sw),
    .o_rn(rn), .o_busy(busy), .o_done(done)
  );

  rn_release_sequencer #(.N_OUT(1), .HOLD_CYC(1), .STAGGER_CYC(1), .CNT_W(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_sw_rst_req(sw1),
    .o_rn(rn1), .o_busy(busy1), .o_done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected domains released after edge e counted from the first low-sampled edge.
  function automatic int released(input int e);
    int r;
    if (e < HOLD) return 0;
    r = (e - HOLD) / STAG + 1;
    return (r > NO) ? NO : r;
  endfunction

  task automatic run_seq(input string name, input int n_edges);
    int r;
    logic [31:0] therm;
    for (int e = 1; e <= n_edges; e++) begin
      tick();
      r     = released(e);
      therm = (32'd1 << r) - 32'd1;
      chk($sformatf("%s rn e%0d", name, e), 32'(rn), therm);
      chk($sformatf("%s busy e%0d", name, e), 32'(busy), 32'(r < NO));
      chk($sformatf("%s done e%0d", name, e), 32'(done), 32'(r == NO));
    end
  endtask

  task automatic chk_assert_state(input string name);
    chk({name, " rn"}, 32'(rn), 32'h0);
    chk({name, " busy"}, 32'(busy), 32'h1);
    chk({name, " done"}, 32'(done), 32'h0);
  endtask

  initial begin
    rst  = 1'b1;
    sw   = 1'b0;
    rst1 = 1'b1;
    sw1  = 1'b0;

    // single-domain instance, HOLD_CYC=1
    tick();
    tick();
    chk("t5 reset rn", 32'(rn1), 32'h0);
    chk("t5 reset busy", 32'(busy1), 32'h1);
    chk("t5 reset done", 32'(done1), 32'h0);
    rst1 = 1'b0;
    tick();
    chk("t5 rn e1", 32'(rn1), 32'h1);
    chk("t5 done e1", 32'(done1), 32'h1);
    chk("t5 busy e1", 32'(busy1), 32'h0);
    tick();
    chk("t5 rn e2", 32'(rn1), 32'h1);

    // test 1: reset then defaults
    rst = 1'b1;
    tick();
    chk_assert_state("t1 reset");
    rst = 1'b0;
    run_seq("t1", 22);

    // test 2: one-cycle soft request in RUN
    sw = 1'b1;
    tick();
    chk_assert_state("t2 req");
    sw = 1'b0;
    run_seq("t2", 22);

    // test 3: soft request at edge 14 mid-release
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_seq("t3 pre", 13);
    sw = 1'b1;
    tick();
    chk_assert_state("t3 req e14");
    sw = 1'b0;
    run_seq("t3 post", 22);

    // test 4: RST together with soft request mid-release
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_seq("t4 pre", 13);
    rst = 1'b1;
    sw  = 1'b1;
    tick();
    chk_assert_state("t4 rst");
    rst = 1'b0;
    sw  = 1'b0;
    run_seq("t4 post", 22);

    // test 6: soft request held for 10 edges
    sw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_assert_state($sformatf("t6 hold%0d", k));
    end
    sw = 1'b0;
    run_seq("t6 post", 22);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
